// File: rtl/priority_encoder_hs.sv
// priority_encoder_hs: registered 8-bit priority encoder with valid/ready
// handshake on both sides, one-cycle latency and full-throughput streaming.
module priority_encoder_hs #(
  parameter int PRIO_MSB = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] y,
  output logic       zero,
  output logic       multi,
  output logic [7:0] xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state;
  logic       in_xfer;
  logic       out_xfer;
  logic [2:0] enc;
  logic [3:0] ones;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Encode the winning set bit of d and count its set bits.
  always_comb begin
    enc  = '0;
    ones = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      ones = ones + 4'(d[i]);
      if (PRIO_MSB != 0) begin
        if (d[i]) enc = 3'(i);
      end else begin
        if (d[7 - i]) enc = 3'(7 - i);
      end
    end
  end

  // Handshake FSM, result registers and output-transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      y        <= '0;
      zero     <= 1'b0;
      multi    <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (out_xfer) xfer_cnt <= xfer_cnt + 8'd1;
      if (in_xfer) begin
        state <= FULL;
        y     <= enc;
        zero  <= (d == 8'h00);
        multi <= (ones >= 4'd2);
      end else if (out_xfer) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: doc/priority_encoder_hs.md
PRIORITY_ENCODER_HS -- requirements
Module: priority_encoder_hs

Interface
REQ-001 Parameter: PRIO_MSB, default 1, selects the winning set bit: 1 = highest index wins, 0 = lowest index wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  d holds a request vector.
REQ-005 in_ready  output  1  block can accept d this cycle.
REQ-006 d  input  8  request vector, any number of bits set.
REQ-007 out_valid  output  1  y/zero/multi hold a result.
REQ-008 out_ready  input  1  sink consumes the result this cycle.
REQ-009 y  output  3  encoded index of the winning set bit.
REQ-010 zero  output  1  captured d was 8'h00.
REQ-011 multi  output  1  captured d had two or more bits set.
REQ-012 xfer_cnt  output  8  count of completed output transfers, wraps 255->0.

Function
REQ-013 Input transfer SHALL occur on a rising edge where in_valid && in_ready.
REQ-014 Output transfer SHALL occur on a rising edge where out_valid && out_ready.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally, to allow one transfer per cycle at full throughput.
REQ-016 The FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 EMPTY -> FULL on input transfer.
REQ-018 FULL -> EMPTY on output transfer without simultaneous input transfer.
REQ-019 FULL stays FULL on simultaneous output and input transfer, with the result registers loaded from the new d in the same edge.
REQ-020 Latency SHALL be exactly one cycle: a result is visible on y/zero/multi with out_valid=1 in the cycle after its input transfer.
REQ-021 While FULL and out_ready=0, y, zero and multi SHALL hold stable, in_ready SHALL be 0, and d SHALL be ignored.
REQ-022 With PRIO_MSB=1, y SHALL be the index of the highest set bit of the captured d. With PRIO_MSB=0, y SHALL be the index of the lowest set bit.
REQ-023 For d=8'h00, the block SHALL set y=3'b000 and zero=1, SHALL transfer the result normally, and SHALL never stall.
REQ-024 multi SHALL be 1 iff the popcount of the captured d is at least 2. zero and multi SHALL never both be 1.
REQ-025 xfer_cnt SHALL increment by 1 on each output transfer, modulo 256, and SHALL not change otherwise.
REQ-026 in_valid deasserted SHALL cause no state change, except that an output transfer empties the block.

Reset
REQ-027 While rst_n=0, regardless of clk, the outputs SHALL be: out_valid=0, y=3'b000, zero=0, multi=0, xfer_cnt=8'h00, FSM=EMPTY.
REQ-028 While rst_n=0, in_ready SHALL be 1, per REQ-015.
REQ-029 Reset asserted while FULL SHALL discard the held result. No output transfer SHALL be counted for it.
REQ-030 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-031 Reset, then d=8'b0010_0100, in_valid=1, out_ready=1 for one cycle, PRIO_MSB=1 -> next cycle: out_valid=1, y=3'd5, multi=1, zero=0, xfer_cnt=1 after the following edge.
REQ-032 PRIO_MSB=0, same d=8'b0010_0100 -> y=3'd2, multi=1.
REQ-033 d=8'h00 -> y=0, zero=1, multi=0, out_valid=1 one cycle later.
REQ-034 Back-pressure: load d=8'h80, hold out_ready=0 for 3 cycles while d=8'h01, in_valid=1 -> in_ready=0, y stays 3'd7 for all 3 cycles; out_ready=1 -> 8'h80 result transfers and 8'h01 is accepted on the same edge, then y=0, multi=0.
REQ-035 Streaming: in_valid=1, out_ready=1 for 256 consecutive one-hot vectors cycling 8'h01..8'h80 -> y sequence 0..7 repeating, one result per cycle, xfer_cnt wraps to 8'h00.
REQ-036 Assert rst_n=0 mid-cycle while FULL with out_ready=0 -> out_valid=0 and xfer_cnt=0 immediately, without waiting for a clock edge.
